regfile_scoreboard: RTL and testbench

- Parametrised next-generation register file for the pipelined core's decode stage.
- Generalises the fixed 32x32, two-read-port file to configurable width, depth and read-port count.
- Replaces negedge write timing with a posedge write plus same-cycle write-to-read bypass.
- Adds a pending-write scoreboard so decode can stall on variable-latency producers such as multi-cycle loads, instead of only single-cycle load-use.
- Sits in ID: feeds operands and the branch-equal flag forward, and drives the stall line to PC and IF/ID.

---
 rtl/regfile_scoreboard_pkg.sv | 14 +
 rtl/regfile_scoreboard_sb.sv | 75 +++++++
 rtl/regfile_scoreboard.sv | 83 ++++++++
 tb/tb_regfile_scoreboard.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared widths and constants for the ID-stage register file.
// Address qualification is common to storage, forwarding and scoreboard.
package regfile_scoreboard_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_NUM_RD   = 2;
    localparam int REG_ZERO     = 0;

    function automatic logic addr_valid(input int a, input int num_regs);
        return (a != REG_ZERO) && (a < num_regs);
    endfunction

endpackage

// File: rtl/regfile_scoreboard_sb.sv
// Pending-write scoreboard: tracks long-latency producers and raises stall.
// Set on issue beats a same-cycle clear so the newest producer stays tracked.
module regfile_scoreboard_sb
    import regfile_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int BYPASS   = 1,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD-1:0]        rd_use,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_dst,
    input  logic                     flush_en,
    input  logic [ADDR_W-1:0]        flush_dst,
    output logic                     stall,
    output logic [NUM_REGS-1:0]      pending
);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;
    logic [NUM_RD-1:0]   port_hold;
    logic                rd_hold;
    logic                waw_hold;
    logic                issue_clr;
    logic                issue_ok;

    // Without bypass the writeback value is not visible yet, so no exemption.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        logic [ADDR_W-1:0] a;
        logic              fwd;
        assign a   = rd_addr[i*ADDR_W +: ADDR_W];
        assign fwd = (BYPASS != 0) && wr_en && (wr_addr == a);
        assign port_hold[i] = rd_use[i]
                            && addr_valid(int'(a), NUM_REGS)
                            && pend_q[a]
                            && !fwd;
    end

    assign rd_hold   = |port_hold;
    assign issue_clr = (wr_en && (wr_addr == issue_dst))
                    || (flush_en && (flush_dst == issue_dst));
    assign issue_ok  = addr_valid(int'(issue_dst), NUM_REGS);
    assign waw_hold  = issue_en && issue_ok
                    && pend_q[issue_dst] && !issue_clr;
    assign stall     = rd_hold || waw_hold;
    assign pending   = pend_q;

    always_comb begin
        pend_d = pend_q;
        if (wr_en && addr_valid(int'(wr_addr), NUM_REGS)) begin
            pend_d[wr_addr] = 1'b0;
        end
        if (flush_en && addr_valid(int'(flush_dst), NUM_REGS)) begin
            pend_d[flush_dst] = 1'b0;
        end
        if (issue_en && !stall && issue_ok) begin
            pend_d[issue_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// ID-stage register file with posedge write, write-to-read bypass,
// branch-equal compare and a pending-write scoreboard for stalls.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int NUM_REGS = DEF_NUM_REGS,
    parameter  int NUM_RD   = DEF_NUM_RD,
    parameter  int BYPASS   = 1,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD-1:0]        rd_use,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     equal,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_dst,
    input  logic                     flush_en,
    input  logic [ADDR_W-1:0]        flush_dst,
    output logic                     stall,
    output logic [NUM_REGS-1:0]      pending
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_ok;

    assign wr_ok = wr_en && addr_valid(int'(wr_addr), NUM_REGS);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Invalid addresses (r0 or beyond NUM_REGS) read as zero, even on a hit.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              ok;
        logic              fwd;
        assign a   = rd_addr[i*ADDR_W +: ADDR_W];
        assign ok  = addr_valid(int'(a), NUM_REGS);
        assign fwd = (BYPASS != 0) && wr_en && (wr_addr == a);
        assign rd_data[i*DATA_W +: DATA_W] = !ok ? '0
                                           : fwd ? wr_data
                                           : regs[a];
    end

    if (NUM_RD >= 2) begin : g_eq
        assign equal = rd_data[DATA_W-1:0] == rd_data[2*DATA_W-1:DATA_W];
    end else begin : g_no_eq
        assign equal = 1'b0;
    end

    regfile_scoreboard_sb #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .BYPASS   (BYPASS),
        .ADDR_W   (ADDR_W)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_use    (rd_use),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .issue_en  (issue_en),
        .issue_dst (issue_dst),
        .flush_en  (flush_en),
        .flush_dst (flush_dst),
        .stall     (stall),
        .pending   (pending)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: default build plus a 3-port, 16-bit,
// 16-register build without bypass, both against an array-based model.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [4:0]  ra   [2][3];
    logic [2:0]  ruse [2];
    logic        we   [2];
    logic [4:0]  wa   [2];
    logic [31:0] wd   [2];
    logic        ie   [2];
    logic [4:0]  id   [2];
    logic        fe   [2];
    logic [4:0]  fd   [2];

    logic [9:0]  rda_a;
    logic [63:0] rd_a;
    logic        eq_a;
    logic        st_a;
    logic [31:0] pv_a;
    logic [11:0] rda_b;
    logic [47:0] rd_b;
    logic        eq_b;
    logic        st_b;
    logic [15:0] pv_b;

    assign rda_a = {ra[0][1], ra[0][0]};
    assign rda_b = {ra[1][2][3:0], ra[1][1][3:0], ra[1][0][3:0]};

    regfile_scoreboard dut_a (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rda_a),
        .rd_use    (ruse[0][1:0]),
        .rd_data   (rd_a),
        .equal     (eq_a),
        .wr_en     (we[0]),
        .wr_addr   (wa[0]),
        .wr_data   (wd[0]),
        .issue_en  (ie[0]),
        .issue_dst (id[0]),
        .flush_en  (fe[0]),
        .flush_dst (fd[0]),
        .stall     (st_a),
        .pending   (pv_a)
    );

    regfile_scoreboard #(
        .DATA_W   (16),
        .NUM_REGS (16),
        .NUM_RD   (3),
        .BYPASS   (0)
    ) dut_b (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rda_b),
        .rd_use    (ruse[1]),
        .rd_data   (rd_b),
        .equal     (eq_b),
        .wr_en     (we[1]),
        .wr_addr   (wa[1][3:0]),
        .wr_data   (wd[1][15:0]),
        .issue_en  (ie[1]),
        .issue_dst (id[1][3:0]),
        .flush_en  (fe[1]),
        .flush_dst (fd[1][3:0]),
        .stall     (st_b),
        .pending   (pv_b)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_regs [2][32];
    bit          m_pend [2][32];

    function automatic int nrd(int k);
        return (k == 0) ? 2 : 3;
    endfunction

    function automatic int nregs(int k);
        return (k == 0) ? 32 : 16;
    endfunction

    function automatic bit byp(int k);
        return k == 0;
    endfunction

    function automatic logic [31:0] mask(int k);
        return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    function automatic bit m_ok(int k, int a);
        return (a != 0) && (a < nregs(k));
    endfunction

    function automatic logic [31:0] m_read(int k, int p);
        int a;
        a = int'(ra[k][p]);
        if (!m_ok(k, a)) return 32'h0;
        if (byp(k) && we[k] && int'(wa[k]) == a) return wd[k] & mask(k);
        return m_regs[k][a];
    endfunction

    function automatic bit m_stall(int k);
        int a;
        bit clr;
        for (int p = 0; p < nrd(k); p++) begin
            a = int'(ra[k][p]);
            if (ruse[k][p] && m_ok(k, a) && m_pend[k][a]
                && !(byp(k) && we[k] && int'(wa[k]) == a)) return 1'b1;
        end
        clr = (we[k] && wa[k] == id[k]) || (fe[k] && fd[k] == id[k]);
        return ie[k] && m_ok(k, int'(id[k])) && m_pend[k][id[k]] && !clr;
    endfunction

    function automatic logic [31:0] m_pvec(int k);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < nregs(k); i++) v[i] = m_pend[k][i];
        return v;
    endfunction

    task automatic m_clock(int k);
        bit st;
        st = m_stall(k);
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[k][i] = '0;
                m_pend[k][i] = 1'b0;
            end
        end else begin
            if (we[k] && m_ok(k, int'(wa[k]))) begin
                m_regs[k][wa[k]] = wd[k] & mask(k);
                m_pend[k][wa[k]] = 1'b0;
            end
            if (fe[k] && m_ok(k, int'(fd[k]))) m_pend[k][fd[k]] = 1'b0;
            if (ie[k] && !st && m_ok(k, int'(id[k]))) m_pend[k][id[k]] = 1'b1;
        end
    endtask

    task automatic cmp(string name, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s unit%0d got %h want %h at %0t",
                     name, k, act, exp, $time);
        end
    endtask

    task automatic check_unit(int k);
        logic [31:0] act;
        for (int p = 0; p < nrd(k); p++) begin
            act = (k == 0) ? rd_a[p*32 +: 32] : {16'h0, rd_b[p*16 +: 16]};
            cmp("rd_data", k, act, m_read(k, p));
        end
        cmp("equal", k, {31'h0, (k == 0) ? eq_a : eq_b},
            {31'h0, m_read(k, 0) == m_read(k, 1)});
        cmp("stall", k, {31'h0, (k == 0) ? st_a : st_b}, {31'h0, m_stall(k)});
        cmp("pending", k, (k == 0) ? pv_a : {16'h0, pv_b}, m_pvec(k));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) m_clock(k);
            @(negedge clk);
            if (chk_en) for (int k = 0; k < 2; k++) check_unit(k);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 3; p++) ra[k][p] = '0;
            ruse[k] = '0;
            we[k] = 1'b0;
            wa[k] = '0;
            wd[k] = '0;
            ie[k] = 1'b0;
            id[k] = '0;
            fe[k] = 1'b0;
            fd[k] = '0;
        end
    endtask

    function automatic logic [4:0] rnd_addr(int k);
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, nregs(k) - 1));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_en = 1'b1;

        ra[0][0] = 5'd5;
        ra[0][1] = 5'd9;
        #3;
        cmp("rst_rd", 0, rd_a[31:0] | rd_a[63:32], 32'h0);
        cmp("rst_eq", 0, {31'h0, eq_a}, 32'h1);
        cmp("rst_stall", 0, {31'h0, st_a}, 32'h0);
        cmp("rst_pend", 0, pv_a, 32'h0);
        step();

        for (int k = 0; k < 2; k++) begin
            we[k] = 1'b1;
            wa[k] = 5'd7;
            wd[k] = 32'hDEAD_BEEF;
            ra[k][0] = 5'd7;
        end
        #3;
        cmp("byp_same", 0, rd_a[31:0], 32'hDEAD_BEEF);
        cmp("nobyp_same", 1, {16'h0, rd_b[15:0]}, 32'h0);
        step();
        we[0] = 1'b0;
        we[1] = 1'b0;
        #3;
        cmp("byp_next", 0, rd_a[31:0], 32'hDEAD_BEEF);
        cmp("nobyp_next", 1, {16'h0, rd_b[15:0]}, 32'h0000_BEEF);
        step();

        idle();
        we[0] = 1'b1;
        wa[0] = 5'd0;
        wd[0] = 32'h1234;
        step();
        idle();
        #3;
        cmp("r0_read", 0, rd_a[31:0], 32'h0);
        ie[0] = 1'b1;
        id[0] = 5'd0;
        #1;
        cmp("r0_issue_stall", 0, {31'h0, st_a}, 32'h0);
        step();
        idle();
        #3;
        cmp("r0_pend", 0, pv_a, 32'h0);

        ie[0] = 1'b1;
        id[0] = 5'd3;
        step();
        idle();
        ra[0][0] = 5'd3;
        ruse[0] = 3'b001;
        for (int c = 0; c < 3; c++) begin
            #3;
            cmp("load_use_stall", 0, {31'h0, st_a}, 32'h1);
            step();
        end
        we[0] = 1'b1;
        wa[0] = 5'd3;
        wd[0] = 32'h55;
        #3;
        cmp("wb_release", 0, {31'h0, st_a}, 32'h0);
        cmp("wb_fwd", 0, rd_a[31:0], 32'h55);
        step();
        idle();
        #3;
        cmp("wb_clear", 0, pv_a, 32'h0);

        ie[0] = 1'b1;
        id[0] = 5'd3;
        step();
        idle();
        ra[0][0] = 5'd3;
        #3;
        cmp("unused_port", 0, {31'h0, st_a}, 32'h0);
        ie[0] = 1'b1;
        id[0] = 5'd3;
        #1;
        cmp("waw_stall", 0, {31'h0, st_a}, 32'h1);
        step();
        idle();
        fe[0] = 1'b1;
        fd[0] = 5'd3;
        step();
        idle();
        #3;
        cmp("flush_clear", 0, pv_a, 32'h0);

        ie[0] = 1'b1;
        id[0] = 5'd4;
        we[0] = 1'b1;
        wa[0] = 5'd4;
        wd[0] = 32'h99;
        step();
        idle();
        #3;
        cmp("set_wins", 0, pv_a, 32'h0000_0010);
        ra[0][0] = 5'd4;
        ruse[0] = 3'b001;
        reset = 1'b1;
        #1;
        cmp("pre_rst_stall", 0, {31'h0, st_a}, 32'h1);
        step();
        reset = 1'b0;
        #3;
        cmp("mid_rst_pend", 0, pv_a, 32'h0);
        cmp("mid_rst_stall", 0, {31'h0, st_a}, 32'h0);

        idle();
        we[1] = 1'b1;
        wa[1] = 5'd15;
        wd[1] = 32'hFFFF;
        step();
        idle();
        ra[1][0] = 5'd15;
        ra[1][1] = 5'd15;
        ra[1][2] = 5'd1;
        #3;
        cmp("p3_rd", 1, {16'h0, rd_b[47:32]} | {rd_b[31:16], rd_b[15:0]},
            32'hFFFF_FFFF);
        cmp("p3_rd2", 1, {16'h0, rd_b[47:32]}, 32'h0);
        cmp("p3_eq", 1, {31'h0, eq_b}, 32'h1);
        step();

        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < 2; k++) begin
                for (int p = 0; p < 3; p++) ra[k][p] = rnd_addr(k);
                ruse[k] = 3'($urandom);
                we[k] = ($urandom_range(0, 2) == 0);
                wa[k] = rnd_addr(k);
                wd[k] = $urandom & mask(k);
                ie[k] = ($urandom_range(0, 2) == 0);
                id[k] = rnd_addr(k);
                fe[k] = ($urandom_range(0, 6) == 0);
                fd[k] = rnd_addr(k);
            end
            step();
        end
        reset = 1'b0;
        idle();
        step();
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
